// File: rtl/capture_sram.sv
// Triggered circular sample-capture buffer. It keeps PRE_TRIG samples from before the trigger,
// fills the rest of memory after the trigger, then freezes for readout over a 1-cycle-latency port.
module capture_sram #(
   parameter int ADDR_WIDTH = 6,
   parameter int DATA_WIDTH = 32,
   parameter int PRE_TRIG   = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  arm_i,
   input  logic                  trig_i,
   input  logic [DATA_WIDTH-1:0] sample_i,
   input  logic                  sample_valid_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [ADDR_WIDTH-1:0] trig_pos_o,
   output logic [ADDR_WIDTH-1:0] start_addr_o,
   input  logic [ADDR_WIDTH-1:0] mem_addr_i,
   output logic [DATA_WIDTH-1:0] mem_data_o
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] PRE_TRIG_W = ADDR_WIDTH'(PRE_TRIG);
   localparam logic [ADDR_WIDTH-1:0] POST_INIT  = ADDR_WIDTH'(DEPTH - PRE_TRIG - 1);
   localparam logic [ADDR_WIDTH-1:0] ONE        = ADDR_WIDTH'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRE,
      S_ARMED,
      S_POST,
      S_DONE
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic                  w_wr_en;
   logic                  w_trig_hit;
   logic [ADDR_WIDTH-1:0] r_wr_ptr;
   logic [ADDR_WIDTH-1:0] r_pre_cnt;
   logic [ADDR_WIDTH-1:0] r_post_cnt;
   logic [ADDR_WIDTH-1:0] r_trig_pos;
   logic [DATA_WIDTH-1:0] r_mem_data;
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   // arm_i overrides everything, including the write of a sample arriving in the same cycle
   always_comb begin
      w_state_nxt = r_state;
      w_wr_en     = 1'b0;
      w_trig_hit  = 1'b0;
      if (arm_i) begin
         w_state_nxt = (PRE_TRIG == 0) ? S_ARMED : S_PRE;
      end else begin
         case (r_state)
            S_PRE: begin
               if (sample_valid_i) begin
                  w_wr_en = 1'b1;
                  if (r_pre_cnt + ONE == PRE_TRIG_W) begin
                     w_state_nxt = S_ARMED;
                  end
               end
            end
            S_ARMED: begin
               if (sample_valid_i) begin
                  w_wr_en = 1'b1;
                  if (trig_i) begin
                     w_trig_hit  = 1'b1;
                     w_state_nxt = (POST_INIT == '0) ? S_DONE : S_POST;
                  end
               end
            end
            S_POST: begin
               if (sample_valid_i) begin
                  w_wr_en = 1'b1;
                  if (r_post_cnt == ONE) begin
                     w_state_nxt = S_DONE;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state    <= S_IDLE;
         r_wr_ptr   <= '0;
         r_pre_cnt  <= '0;
         r_post_cnt <= '0;
         r_trig_pos <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (arm_i) begin
            r_wr_ptr  <= '0;
            r_pre_cnt <= '0;
         end else begin
            if (w_wr_en) begin
               r_wr_ptr <= r_wr_ptr + ONE;
            end
            if (w_wr_en && r_state == S_PRE) begin
               r_pre_cnt <= r_pre_cnt + ONE;
            end
            if (w_trig_hit) begin
               r_trig_pos <= r_wr_ptr;
               r_post_cnt <= POST_INIT;
            end
            if (w_wr_en && r_state == S_POST) begin
               r_post_cnt <= r_post_cnt - ONE;
            end
         end
      end
   end

   // Storage has no reset, so the simple dual-port RAM can be inferred cleanly.
   always_ff @(posedge clk_i) begin
      if (w_wr_en) begin
         r_mem[r_wr_ptr] <= sample_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_mem_data <= '0;
      end else begin
         r_mem_data <= r_mem[mem_addr_i];
      end
   end

   assign busy_o       = (r_state == S_PRE) || (r_state == S_ARMED) || (r_state == S_POST);
   assign done_o       = (r_state == S_DONE);
   assign trig_pos_o   = r_trig_pos;
   assign start_addr_o = r_trig_pos - PRE_TRIG_W;
   assign mem_data_o   = r_mem_data;

endmodule
